// File: rtl/timer_sched_pkg.sv
// ---------------------------------------------------------------------------
// timer_sched_pkg - timer register map, scheduler states and delay floor.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package timer_sched_pkg;

    localparam logic [31:0] TMR_CTRL_ADDR   = {2'b01, 30'h00};
    localparam logic [31:0] TMR_LOAD_ADDR   = {2'b01, 30'h04};
    localparam logic [31:0] TMR_STATUS_ADDR = {2'b01, 30'h14};

    // The timer flags counts of 0 or 1 as expired on the first read.
    localparam int MIN_DELAY = 2;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WR_EN     = 3'd1,
        WR_LOAD   = 3'd2,
        CHK       = 3'd3,
        SETTLE    = 3'd4,
        POLL      = 3'd5,
        WR_DIS    = 3'd6,
        ABORT_ERR = 3'd7
    } sched_state_e;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter - combinational round-robin pick of the first request at or after ptr_i.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
    output logic [NUM_REQ-1:0]         gnt_o,
    output logic [$clog2(NUM_REQ)-1:0] idx_o,
    output logic                       valid_o
);

    localparam int IW = $clog2(NUM_REQ);

    int cand;

    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = (int'(ptr_i) + i) % NUM_REQ;
            if (!valid_o && req_i[cand]) begin
                valid_o     = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = IW'(cand);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/timer_scheduler.sv
// ---------------------------------------------------------------------------
// timer_scheduler - shares one timer among NUM_REQ one-shot delay requesters.
// Optional TIMER_SCHED_POLL_TIMEOUT_EN: POLL watchdog plus sticky timeout_flag.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module timer_scheduler
    import timer_sched_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int SETTLE_CYC = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_delay,
    output logic [NUM_REQ-1:0]            done,
    output logic                          err,
    output logic [$clog2(NUM_REQ)-1:0]    err_id,
    output logic                          busy,
`ifdef TIMER_SCHED_POLL_TIMEOUT_EN
    output logic                          timeout_flag,
`endif
    input  logic [6:0]                    cfg_ctrl_hi,
    output logic                          tmr_rd_en,
    output logic                          tmr_wr_en,
    output logic [ADDR_WIDTH-1:0]         tmr_address,
    output logic [DATA_WIDTH-1:0]         tmr_wr_data,
    input  logic [DATA_WIDTH-1:0]         tmr_rd_data,
    input  logic                          tmr_ready,
    input  logic                          tmr_error
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = DATA_WIDTH + 1;

    sched_state_e            state_q, state_d;
    logic [IW-1:0]           ptr_q, ptr_d, gnt_idx_q, gnt_idx_d, err_id_q, err_id_d;
    logic [NUM_REQ-1:0]      gnt_oh_q, gnt_oh_d, done_q, done_d;
    logic [DATA_WIDTH-1:0]   delay_q, delay_d, wdata_q, wdata_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    wdraw_q, wdraw_d, err_q, err_d, busy_q, busy_d;
    logic                    rd_q, rd_d, wr_q, wr_d;
`ifdef TIMER_SCHED_POLL_TIMEOUT_EN
    logic                    timeout_q, timeout_d;
`endif

    logic [NUM_REQ-1:0]      w_gnt_oh;
    logic [IW-1:0]           w_gnt_idx, w_ptr_next;
    logic                    w_gnt_vld, w_own_req, w_expired, w_unused_rd;
    logic [DATA_WIDTH-1:0]   w_sel_delay, w_clamped;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .gnt_o   (w_gnt_oh),
        .idx_o   (w_gnt_idx),
        .valid_o (w_gnt_vld)
    );

    assign w_sel_delay = req_delay[int'(w_gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
    assign w_clamped   = (w_sel_delay < DATA_WIDTH'(MIN_DELAY)) ? DATA_WIDTH'(MIN_DELAY) : w_sel_delay;
    assign w_ptr_next  = (gnt_idx_q == IW'(NUM_REQ - 1)) ? '0 : gnt_idx_q + 1'b1;
    assign w_own_req   = |(req & gnt_oh_q);
    assign w_expired   = tmr_ready && tmr_rd_data[0];
    assign w_unused_rd = ^tmr_rd_data[DATA_WIDTH-1:1];

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_idx_d = gnt_idx_q;
        gnt_oh_d  = gnt_oh_q;
        delay_d   = delay_q;
        cnt_d     = cnt_q;
        wdraw_d   = wdraw_q;
`ifdef TIMER_SCHED_POLL_TIMEOUT_EN
        timeout_d = timeout_q;
`endif
        case (state_q)
            IDLE: begin
                if (w_gnt_vld) begin
                    state_d   = WR_EN;
                    gnt_idx_d = w_gnt_idx;
                    gnt_oh_d  = w_gnt_oh;
                    delay_d   = w_clamped;
                    wdraw_d   = 1'b0;
                end
            end
            WR_EN:   state_d = WR_LOAD;
            WR_LOAD: state_d = CHK;
            CHK: begin
                if (tmr_error) begin
                    state_d = ABORT_ERR;
                end else begin
                    state_d = SETTLE;
                    cnt_d   = CW'(SETTLE_CYC - 1);
                end
            end
            SETTLE: begin
                if (!w_own_req) begin
                    state_d = WR_DIS;
                    wdraw_d = 1'b1;
                end else if (cnt_q == '0) begin
                    state_d = POLL;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            POLL: begin
                if (!w_own_req) begin
                    state_d = WR_DIS;
                    wdraw_d = 1'b1;
                end else if (w_expired) begin
                    state_d = WR_DIS;
`ifdef TIMER_SCHED_POLL_TIMEOUT_EN
                end else if (cnt_q >= ({1'b0, delay_q} + CW'(8))) begin
                    state_d   = ABORT_ERR;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            default: state_d = IDLE;
        endcase

        // Both exits release the grant, so the next pass starts after it.
        if (state_d == WR_DIS || state_d == ABORT_ERR) begin
            ptr_d = w_ptr_next;
        end

        // Bus and status outputs are registered: decode them from the state being entered.
        rd_d     = 1'b0;
        wr_d     = 1'b0;
        addr_d   = '0;
        wdata_d  = '0;
        done_d   = '0;
        err_d    = 1'b0;
        err_id_d = '0;
        busy_d   = (state_d != IDLE);
        case (state_d)
            WR_EN: begin
                wr_d    = 1'b1;
                addr_d  = ADDR_WIDTH'(TMR_CTRL_ADDR);
                wdata_d = DATA_WIDTH'({cfg_ctrl_hi, 1'b1});
            end
            WR_LOAD: begin
                wr_d    = 1'b1;
                addr_d  = ADDR_WIDTH'(TMR_LOAD_ADDR);
                wdata_d = delay_d;
            end
            POLL: begin
                rd_d   = 1'b1;
                addr_d = ADDR_WIDTH'(TMR_STATUS_ADDR);
            end
            WR_DIS: begin
                wr_d    = 1'b1;
                addr_d  = ADDR_WIDTH'(TMR_CTRL_ADDR);
                wdata_d = DATA_WIDTH'({cfg_ctrl_hi, 1'b0});
                done_d  = wdraw_d ? '0 : gnt_oh_d;
            end
            ABORT_ERR: begin
                wr_d     = 1'b1;
                addr_d   = ADDR_WIDTH'(TMR_CTRL_ADDR);
                wdata_d  = DATA_WIDTH'({cfg_ctrl_hi, 1'b0});
                err_d    = 1'b1;
                err_id_d = gnt_idx_d;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            gnt_idx_q <= '0;
            gnt_oh_q  <= '0;
            delay_q   <= '0;
            cnt_q     <= '0;
            wdraw_q   <= 1'b0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            done_q    <= '0;
            err_q     <= 1'b0;
            err_id_q  <= '0;
            busy_q    <= 1'b0;
`ifdef TIMER_SCHED_POLL_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_idx_q <= gnt_idx_d;
            gnt_oh_q  <= gnt_oh_d;
            delay_q   <= delay_d;
            cnt_q     <= cnt_d;
            wdraw_q   <= wdraw_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            done_q    <= done_d;
            err_q     <= err_d;
            err_id_q  <= err_id_d;
            busy_q    <= busy_d;
`ifdef TIMER_SCHED_POLL_TIMEOUT_EN
            timeout_q <= timeout_d;
`endif
        end
    end

    assign done        = done_q;
    assign err         = err_q;
    assign err_id      = err_id_q;
    assign busy        = busy_q;
    assign tmr_rd_en   = rd_q;
    assign tmr_wr_en   = wr_q;
    assign tmr_address = addr_q;
    assign tmr_wr_data = wdata_q;
`ifdef TIMER_SCHED_POLL_TIMEOUT_EN
    assign timeout_flag = timeout_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_timer_scheduler.sv
// ---------------------------------------------------------------------------
// tb_timer_scheduler - scoreboard bench with a behavioural timer for timer_scheduler.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_timer_scheduler;
    import timer_sched_pkg::*;

    localparam int NR = 4;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int SC = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req;
    logic [NR*DW-1:0]  req_delay;
    logic [NR-1:0]     done;
    logic              err;
    logic [1:0]        err_id;
    logic              busy;
    logic [6:0]        cfg_ctrl_hi;
    logic              tmr_rd_en, tmr_wr_en;
    logic [AW-1:0]     tmr_address;
    logic [DW-1:0]     tmr_wr_data, tmr_rd_data;
    logic              tmr_ready, tmr_error;
`ifdef TIMER_SCHED_POLL_TIMEOUT_EN
    logic              timeout_flag;
`endif

    timer_scheduler #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SETTLE_CYC(SC)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_delay   (req_delay),
        .done        (done),
        .err         (err),
        .err_id      (err_id),
        .busy        (busy),
`ifdef TIMER_SCHED_POLL_TIMEOUT_EN
        .timeout_flag(timeout_flag),
`endif
        .cfg_ctrl_hi (cfg_ctrl_hi),
        .tmr_rd_en   (tmr_rd_en),
        .tmr_wr_en   (tmr_wr_en),
        .tmr_address (tmr_address),
        .tmr_wr_data (tmr_wr_data),
        .tmr_rd_data (tmr_rd_data),
        .tmr_ready   (tmr_ready),
        .tmr_error   (tmr_error)
    );

    always #5 clk = ~clk;

    // Timer model: each STATUS read consumes one tick; expired once at most one tick remains after it.
    logic [31:0] t_cnt;
    logic        t_en, t_err, inj_err, t_expired;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            t_cnt <= '0;
            t_en  <= 1'b0;
            t_err <= 1'b0;
        end else if (tmr_wr_en) begin
            if (tmr_address == TMR_CTRL_ADDR) begin
                t_en <= tmr_wr_data[0];
                if (!tmr_wr_data[0]) t_err <= 1'b0;
            end else if (tmr_address == TMR_LOAD_ADDR) begin
                t_cnt <= tmr_wr_data;
                if (inj_err) t_err <= 1'b1;
            end
        end else if (tmr_rd_en && tmr_address == TMR_STATUS_ADDR && t_cnt != 0) begin
            t_cnt <= t_cnt - 1;
        end
    end

    assign t_expired   = t_en && (t_cnt <= 32'd2);
    assign tmr_ready   = !(tmr_rd_en && !t_expired);
    assign tmr_rd_data = tmr_rd_en ? {31'd0, t_expired} : '0;
    assign tmr_error   = t_err;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    // Scoreboard: expected bus writes {addr,data}, done ids and err ids.
    logic [63:0] exp_wr[$];
    int          exp_done[$];
    int          exp_err[$];
    int          cyc = 0, n_done = 0, n_err = 0, n_rd = 0;
    int          done_cyc = 0, err_cyc = 0, rd_start_cyc = 0;
    logic        prev_rd = 1'b0;
    logic [63:0] mon_e;
    int          mon_id;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            check("bus_excl", 64'(tmr_rd_en & tmr_wr_en), 64'd0);
            if (tmr_rd_en) begin
                n_rd++;
                if (!prev_rd) rd_start_cyc = cyc;
                check("rd_addr", tmr_address, TMR_STATUS_ADDR);
            end
            prev_rd = tmr_rd_en;
            if (tmr_wr_en) begin
                if (exp_wr.size() == 0) check("wr_unexpected", tmr_wr_en, 0);
                else begin
                    mon_e = exp_wr.pop_front();
                    check("wr_access", {tmr_address, tmr_wr_data}, mon_e);
                end
            end
            if (done != '0) begin
                n_done++;
                done_cyc = cyc;
                if (exp_done.size() == 0) check("done_unexpected", done, 0);
                else begin
                    mon_id = exp_done.pop_front();
                    check("done_id", done, 64'(1) << mon_id);
                end
            end
            if (err) begin
                n_err++;
                err_cyc = cyc;
                if (exp_err.size() == 0) check("err_unexpected", err, 0);
                else begin
                    mon_id = exp_err.pop_front();
                    check("err_id", err_id, mon_id);
                end
            end
        end else begin
            prev_rd = 1'b0;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic set_delay(input int id, input int d);
        req_delay[id*DW +: DW] = 32'(d);
    endtask

    // mode: 0 = ends in done, 1 = ends in err, 2 = withdrawn (neither)
    task automatic expect_service(input int id, input int dly, input logic [6:0] hi, input int mode);
        logic [31:0] d;
        d = (dly < 2) ? 32'd2 : 32'(dly);
        exp_wr.push_back({TMR_CTRL_ADDR, 24'd0, hi, 1'b1});
        exp_wr.push_back({TMR_LOAD_ADDR, d});
        exp_wr.push_back({TMR_CTRL_ADDR, 24'd0, hi, 1'b0});
        if (mode == 0) exp_done.push_back(id);
        else if (mode == 1) exp_err.push_back(id);
    endtask

    task automatic wait_done(input int target, input string tag);
        int k = 0;
        while (n_done < target && k < 300) begin step(); k++; end
        check(tag, n_done, target);
    endtask

    task automatic wait_err(input int target, input string tag);
        int k = 0;
        while (n_err < target && k < 300) begin step(); k++; end
        check(tag, n_err, target);
    endtask

    task automatic wait_rd(input int target, input string tag);
        int k = 0;
        while (n_rd < target && k < 300) begin step(); k++; end
        check(tag, n_rd, target);
    endtask

    task automatic wait_wr_drain(input string tag);
        int k = 0;
        while (exp_wr.size() != 0 && k < 300) begin step(); k++; end
        check(tag, exp_wr.size(), 0);
    endtask

    initial begin
        int t0, n;
        rst = 1'b0; req = '0; req_delay = '0; cfg_ctrl_hi = '0; inj_err = 1'b0;
        repeat (3) step();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", {err, err_id}, 0);
        check("rst_rdwr", {tmr_rd_en, tmr_wr_en}, 0);
        check("rst_addr", tmr_address, 0);
        check("rst_wdata", tmr_wr_data, 0);
        rst = 1'b1;
        step();

        // Simultaneous req0/req2 with pointer 0: req0 first, req2 right after.
        expect_service(0, 5, 7'h00, 0);
        expect_service(2, 5, 7'h00, 0);
        set_delay(0, 5); set_delay(2, 5);
        req = 4'b0101; t0 = cyc;
        wait_done(1, "wait_b0"); req[0] = 1'b0;
        check("lat_b0", done_cyc - t0, 5 + SC + 3);
        t0 = done_cyc;
        wait_done(2, "wait_b2"); req[2] = 1'b0;
        check("lat_b2", done_cyc - t0, 5 + SC + 4);

        // Single req1, delay 10: request cycle through done spans delay+SETTLE+4 cycles.
        step();
        expect_service(1, 10, 7'h00, 0);
        set_delay(1, 10); req[1] = 1'b1; t0 = cyc;
        wait_done(3, "wait_c"); req[1] = 1'b0;
        check("lat_c", done_cyc - t0, 10 + SC + 3);

        // Delay 0 clamps to 2; first poll only after the settle window; ctrl high bits carried.
        step();
        cfg_ctrl_hi = 7'h55;
        expect_service(3, 0, 7'h55, 0);
        set_delay(3, 0); req[3] = 1'b1; t0 = cyc;
        wait_done(4, "wait_d"); req[3] = 1'b0;
        check("lat_d", done_cyc - t0, 2 + SC + 3);
        check("settle_gap", rd_start_cyc - t0, SC + 4);

        // Error on the LOAD write: err with req0's id, then req1 is served.
        step();
        inj_err = 1'b1;
        expect_service(0, 4, 7'h55, 1);
        expect_service(1, 6, 7'h55, 0);
        set_delay(0, 4); set_delay(1, 6);
        req = 4'b0011; t0 = cyc;
        wait_err(1, "wait_e_err"); req[0] = 1'b0; inj_err = 1'b0;
        check("lat_e_err", err_cyc - t0, 4);
        wait_done(5, "wait_e1"); req[1] = 1'b0;

        // req3 withdrawn mid-POLL: disable write, no done, busy drops next cycle.
        step();
        cfg_ctrl_hi = 7'h00;
        expect_service(3, 20, 7'h00, 2);
        set_delay(3, 20); req[3] = 1'b1; n = n_rd;
        wait_rd(n + 3, "wait_f_poll"); req[3] = 1'b0;
        wait_wr_drain("wait_f_dis");
        check("wd_no_done", done, 0);
        step();
        check("wd_busy", busy, 0);

        // Move the pointer to 3, then reset during req1's POLL.
        step();
        expect_service(2, 3, 7'h00, 0);
        set_delay(2, 3); req[2] = 1'b1;
        wait_done(6, "wait_g2"); req[2] = 1'b0;
        step();
        exp_wr.push_back({TMR_CTRL_ADDR, 32'h1});
        exp_wr.push_back({TMR_LOAD_ADDR, 32'd30});
        set_delay(1, 30); req[1] = 1'b1; n = n_rd;
        wait_rd(n + 2, "wait_g_poll");
        rst = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_err", {err, err_id}, 0);
        check("mid_rst_rdwr", {tmr_rd_en, tmr_wr_en}, 0);
        check("mid_rst_addr", tmr_address, 0);
        check("mid_rst_wdata", tmr_wr_data, 0);
        check("g_writes_seen", exp_wr.size(), 0);
        req = '0;
        repeat (2) step();
        rst = 1'b1;
        step();
        check("post_rst_busy", busy, 0);

        // Pointer back at 0: req1 wins over req3.
        expect_service(1, 3, 7'h00, 0);
        expect_service(3, 3, 7'h00, 0);
        set_delay(1, 3); set_delay(3, 3);
        req = 4'b1010;
        wait_done(7, "wait_h1"); req[1] = 1'b0;
        wait_done(8, "wait_h3"); req[3] = 1'b0;
        repeat (2) step();

        check("sb_empty", exp_wr.size() + exp_done.size() + exp_err.size(), 0);
`ifdef TIMER_SCHED_POLL_TIMEOUT_EN
        check("timeout_flag", timeout_flag, 0);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/timer_scheduler.md
Name: timer_scheduler

Overview:
- Shares the single timer peripheral among NUM_REQ requesters that each need a one-shot delay.
- Arbitrates the requesters round-robin and drives the timer's register port as its only master.
- For the granted requester, it programs the timer, polls for expiry, disables the timer, and returns a one-cycle done pulse.
- Sits between the requester logic and the timer's rd_en/wr_en/address/wr_data port, replacing direct bus access to the timer.

Parameters:
- NUM_REQ, 4, number of requesters; 2..8.
- DATA_WIDTH, 32, width of the timer data and of the delay values.
- ADDR_WIDTH, 32, width of the timer address.
- SETTLE_CYC, 3, idle cycles between the LOAD write and the first STATUS poll.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  per-requester delay request; level, held until done.
- req_delay  in  NUM_REQ*DATA_WIDTH  packed delay in cycles per requester; must be stable while req is high.
- done  out  NUM_REQ  one-cycle pulse when the requester's delay has expired.
- err  out  1  one-cycle pulse when a service is aborted on a bus error.
- err_id  out  $clog2(NUM_REQ)  requester index for err; valid with err.
- busy  out  1  high in any state other than IDLE.
- cfg_ctrl_hi  in  7  value written to timer ctrl bits [7:1] (watchdog/PWM enables); preserved on every ctrl write.
- tmr_rd_en  out  1  timer read strobe.
- tmr_wr_en  out  1  timer write strobe.
- tmr_address  out  ADDR_WIDTH  timer register address.
- tmr_wr_data  out  DATA_WIDTH  timer write data.
- tmr_rd_data  in  DATA_WIDTH  timer read data.
- tmr_ready  in  1  timer ready; low while STATUS reads not-expired.
- tmr_error  in  1  timer write error flag, registered by the timer.

Behaviour:
- Reset:
  - All outputs 0; tmr_address = 0.
  - FSM in IDLE; round-robin pointer = 0.
- Register map:
  - CTRL = {2'b01,30'h00}.
  - LOAD = {2'b01,30'h04}.
  - STATUS = {2'b01,30'h14}.
- Bus rules:
  - rd_en and wr_en are never high together.
  - Each access lasts exactly one cycle.
  - Outputs are registered.
- FSM:
  - IDLE: if any req is high, the RR arbiter grants the first requester at or after the pointer. Latch gnt_id and delay. Clamp the delay: values below 2 become 2, because the timer reports expired immediately for counts 0/1. Go to WR_EN.
  - WR_EN: write CTRL = {cfg_ctrl_hi,1'b1}. Go to WR_LOAD.
  - WR_LOAD: write LOAD = latched delay. Go to CHK.
  - CHK: one cycle; tmr_error is sampled here for the two writes. If set, go to ABORT_ERR; otherwise go to SETTLE.
  - SETTLE: wait SETTLE_CYC cycles. Go to POLL.
  - POLL: read STATUS every cycle. If tmr_ready=1 and tmr_rd_data[0]=1, go to WR_DIS.
  - WR_DIS: write CTRL = {cfg_ctrl_hi,1'b0}. Pulse done[gnt_id] in the same cycle. Advance the pointer to gnt_id+1 (mod NUM_REQ). Go to IDLE.
  - ABORT_ERR: write CTRL = {cfg_ctrl_hi,1'b0}. Pulse err with err_id=gnt_id; no done. Advance the pointer. Go to IDLE.
- Latency:
  - Minimum request-to-done = 1 (grant) + 2 (writes) + 1 (CHK) + SETTLE_CYC + (delay-1) polls + 1.
  - Total is delay+SETTLE_CYC+4 cycles for delay>=2.
- Request withdrawal: req[gnt_id] dropping in SETTLE or POLL aborts the service. Disable the timer via the WR_DIS write, emit no done, go to IDLE.
- Same-cycle events: done and a new req from the same requester in the same cycle — the new req is serviced only after a full arbitration pass (fairness).
- Reset mid-service: all state is cleared. The timer is also reset by the same rst, so no disable write is needed.

Optional Feature:
- Macro: TIMER_SCHED_POLL_TIMEOUT_EN.
- Defined:
  - A POLL-cycle counter aborts through ABORT_ERR if polling exceeds latched delay + 8 cycles.
  - It also sets sticky output timeout_flag (1 bit, cleared by reset).
- Undefined: the counter and port are absent; POLL waits indefinitely.

Decomposition:
- Package timer_sched_pkg holds:
  - address constants TMR_CTRL_ADDR, TMR_LOAD_ADDR, TMR_STATUS_ADDR;
  - typedef enum sched_state_e {IDLE, WR_EN, WR_LOAD, CHK, SETTLE, POLL, WR_DIS, ABORT_ERR};
  - constant MIN_DELAY = 2.
- One sub-module, rr_arbiter: parameterised by NUM_REQ; inputs req and pointer; outputs one-hot grant and index; purely combinational.

Test Plan:
- req[1]=1, delay=10, others idle -> writes CTRL=0x01 then LOAD=10; done[1] pulses 17 cycles after grant; then a CTRL=0x00 write.
- req[0] and req[2] raised in the same cycle, delay=5 each, pointer=0 -> req0 is served first; done[0] then done[2]; no overlap of bus accesses.
- delay=0 -> clamped to 2; done pulses; timer is never polled before SETTLE completes.
- Timer model asserts tmr_error on the LOAD write -> err pulses with err_id=granted index; no done; timer disabled; next requester is served.
- req[3] drops in the middle of POLL -> CTRL disable write; no done[3]; busy falls the next cycle.
- rst asserted during POLL -> all outputs 0 immediately; after release the FSM is in IDLE and pointer=0.
